// File: rtl/freq_analysis_pkg.sv
// rtl/freq_analysis_pkg.sv - shared widths, bin field positions and scan states for frequency analysis
package freq_analysis_pkg;

    localparam int N_BINS = 16;
    localparam int BIN_W  = 16;
    localparam int MAG_W  = 32;
    localparam int IDX_W  = 4;

    // Packed bin layout: {real, imag}, both signed Q8.8
    localparam int RE_MSB = 31;
    localparam int RE_LSB = 16;
    localparam int IM_MSB = 15;
    localparam int IM_LSB = 0;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_BINS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } scan_state_t;

endpackage

// File: rtl/cplx_mag_sq.sv
// rtl/cplx_mag_sq.sv - combinational |X|^2 = re^2 + im^2 of one signed complex sample
// Ports: re, im (signed Q8.8) in; mag_sq (unsigned Q16.16) out.
module cplx_mag_sq
    import freq_analysis_pkg::*;
(
    input  logic signed [BIN_W-1:0] re,
    input  logic signed [BIN_W-1:0] im,
    output logic        [MAG_W-1:0] mag_sq
);

    logic signed [2*BIN_W-1:0] re_ext;
    logic signed [2*BIN_W-1:0] im_ext;
    logic signed [2*BIN_W-1:0] re_sq;
    logic signed [2*BIN_W-1:0] im_sq;

    assign re_ext = {{BIN_W{re[BIN_W-1]}}, re};
    assign im_ext = {{BIN_W{im[BIN_W-1]}}, im};

    // Each square is at most 2^30, so it is non-negative in 32 bits; the
    // unsigned sum peaks at 2^31 and cannot wrap.
    assign re_sq  = re_ext * re_ext;
    assign im_sq  = im_ext * im_ext;
    assign mag_sq = $unsigned(re_sq) + $unsigned(im_sq);

endmodule

// File: rtl/fft_peak_analysis.sv
// rtl/fft_peak_analysis.sv - captures a 16-bin spectrum frame and reports its strongest bin
// Ports: clk, rst (sync, active-high); fft_valid + fft_d0..fft_d15 frame input;
// done/freq/peak_mag result, busy while scanning, overrun when a frame is dropped.
module fft_peak_analysis
    import freq_analysis_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              fft_valid,
    input  logic [31:0]       fft_d0,
    input  logic [31:0]       fft_d1,
    input  logic [31:0]       fft_d2,
    input  logic [31:0]       fft_d3,
    input  logic [31:0]       fft_d4,
    input  logic [31:0]       fft_d5,
    input  logic [31:0]       fft_d6,
    input  logic [31:0]       fft_d7,
    input  logic [31:0]       fft_d8,
    input  logic [31:0]       fft_d9,
    input  logic [31:0]       fft_d10,
    input  logic [31:0]       fft_d11,
    input  logic [31:0]       fft_d12,
    input  logic [31:0]       fft_d13,
    input  logic [31:0]       fft_d14,
    input  logic [31:0]       fft_d15,
    output logic              done,
    output logic [IDX_W-1:0]  freq,
    output logic [MAG_W-1:0]  peak_mag,
    output logic              busy,
    output logic              overrun
);

    logic [31:0]       bus_in [N_BINS];

    scan_state_t       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [MAG_W-1:0]  best_mag_q, best_mag_d;
    logic [IDX_W-1:0]  best_idx_q, best_idx_d;
    logic              done_q, done_d;
    logic [IDX_W-1:0]  freq_q, freq_d;
    logic [MAG_W-1:0]  peak_mag_q, peak_mag_d;
    logic              busy_q, busy_d;
    logic              overrun_q, overrun_d;
    logic [31:0]       buf_q [N_BINS];
    logic [31:0]       buf_d [N_BINS];

    logic [31:0]       cur_bin;
    logic signed [BIN_W-1:0] cur_re;
    logic signed [BIN_W-1:0] cur_im;
    logic [MAG_W-1:0]  cur_mag;
    logic              cur_better;
    logic [MAG_W-1:0]  run_best_mag;
    logic [IDX_W-1:0]  run_best_idx;

    assign bus_in[0]  = fft_d0;
    assign bus_in[1]  = fft_d1;
    assign bus_in[2]  = fft_d2;
    assign bus_in[3]  = fft_d3;
    assign bus_in[4]  = fft_d4;
    assign bus_in[5]  = fft_d5;
    assign bus_in[6]  = fft_d6;
    assign bus_in[7]  = fft_d7;
    assign bus_in[8]  = fft_d8;
    assign bus_in[9]  = fft_d9;
    assign bus_in[10] = fft_d10;
    assign bus_in[11] = fft_d11;
    assign bus_in[12] = fft_d12;
    assign bus_in[13] = fft_d13;
    assign bus_in[14] = fft_d14;
    assign bus_in[15] = fft_d15;

    assign cur_bin = buf_q[idx_q];
    assign cur_re  = cur_bin[RE_MSB:RE_LSB];
    assign cur_im  = cur_bin[IM_MSB:IM_LSB];

    cplx_mag_sq u_mag (
        .re     (cur_re),
        .im     (cur_im),
        .mag_sq (cur_mag)
    );

    // Strictly greater: on a tie the earlier (lower) bin index is kept.
    assign cur_better   = cur_mag > best_mag_q;
    assign run_best_mag = cur_better ? cur_mag : best_mag_q;
    assign run_best_idx = cur_better ? idx_q   : best_idx_q;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        done_d     = 1'b0;
        freq_d     = freq_q;
        peak_mag_d = peak_mag_q;
        busy_d     = busy_q;
        overrun_d  = 1'b0;
        buf_d      = buf_q;

        case (state_q)
            ST_IDLE: begin
                if (fft_valid) begin
                    buf_d      = bus_in;
                    idx_d      = '0;
                    best_mag_d = '0;
                    best_idx_d = '0;
                    state_d    = ST_SCAN;
                    busy_d     = 1'b1;
                end
            end
            ST_SCAN: begin
                best_mag_d = run_best_mag;
                best_idx_d = run_best_idx;
                idx_d      = idx_q + 1'b1;
                if (idx_q == IDX_LAST) begin
                    done_d     = 1'b1;
                    freq_d     = run_best_idx;
                    peak_mag_d = run_best_mag;
                    // A frame arriving on the last scan edge is taken
                    // directly, giving back-to-back frames every 16 cycles.
                    if (fft_valid) begin
                        buf_d      = bus_in;
                        idx_d      = '0;
                        best_mag_d = '0;
                        best_idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end
                end else if (fft_valid) begin
                    overrun_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            best_mag_q <= '0;
            best_idx_q <= '0;
            done_q     <= 1'b0;
            freq_q     <= '0;
            peak_mag_q <= '0;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            done_q     <= done_d;
            freq_q     <= freq_d;
            peak_mag_q <= peak_mag_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    // Frame buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign done     = done_q;
    assign freq     = freq_q;
    assign peak_mag = peak_mag_q;
    assign busy     = busy_q;
    assign overrun  = overrun_q;

endmodule

// File: tb/tb_fft_peak_analysis.sv
// tb/tb_fft_peak_analysis.sv - directed scoreboard bench for fft_peak_analysis
module tb_fft_peak_analysis;

    logic        clk = 1'b0;
    logic        rst;
    logic        fft_valid;
    logic [31:0] fd [16];
    logic        done;
    logic [3:0]  freq;
    logic [31:0] peak_mag;
    logic        busy;
    logic        overrun;

    int          n_assert = 0;
    int          n_fail   = 0;
    int          done_cnt = 0;
    int          ovr_cnt  = 0;
    logic [35:0] sb [$];
    logic [35:0] sb_exp;

    always #5 clk = ~clk;

    fft_peak_analysis dut (
        .clk       (clk),
        .rst       (rst),
        .fft_valid (fft_valid),
        .fft_d0    (fd[0]),
        .fft_d1    (fd[1]),
        .fft_d2    (fd[2]),
        .fft_d3    (fd[3]),
        .fft_d4    (fd[4]),
        .fft_d5    (fd[5]),
        .fft_d6    (fd[6]),
        .fft_d7    (fd[7]),
        .fft_d8    (fd[8]),
        .fft_d9    (fd[9]),
        .fft_d10   (fd[10]),
        .fft_d11   (fd[11]),
        .fft_d12   (fd[12]),
        .fft_d13   (fd[13]),
        .fft_d14   (fd[14]),
        .fft_d15   (fd[15]),
        .done      (done),
        .freq      (freq),
        .peak_mag  (peak_mag),
        .busy      (busy),
        .overrun   (overrun)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: strongest bin by |X|^2, lowest index on ties.
    function automatic logic [35:0] model(input logic [31:0] f [16]);
        longint best = 0;
        int     bi   = 0;
        for (int k = 0; k < 16; k++) begin
            longint r = longint'($signed(f[k][31:16]));
            longint i = longint'($signed(f[k][15:0]));
            longint m = r * r + i * i;
            if (m > best) begin
                best = m;
                bi   = k;
            end
        end
        return {4'(bi), 32'(best)};
    endfunction

    always @(negedge clk) begin
        if (overrun === 1'b1) ovr_cnt++;
        if (done === 1'b1) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("sb_unexpected_done", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                check("sb_freq", {28'd0, freq}, {28'd0, sb_exp[35:32]});
                check("sb_peak_mag", peak_mag, sb_exp[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_frame();
        for (int k = 0; k < 16; k++) fd[k] = 32'd0;
    endtask

    task automatic cap();
        sb.push_back(model(fd));
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (done !== 1'b1 && n < 40);
    endtask

    initial begin
        int n;
        int d0;
        int o0;

        rst       = 1'b1;
        fft_valid = 1'b0;
        clear_frame();
        tick();
        tick();
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_freq", {28'd0, freq}, 32'd0);
        check("rst_peak", peak_mag, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        rst = 1'b0;
        tick();

        // Single peak; bus scrambled during scan must not matter
        clear_frame();
        fd[5] = 32'h0100_0000;
        cap();
        check("single_busy", {31'd0, busy}, 32'd1);
        for (int k = 0; k < 16; k++) fd[k] = $urandom;
        wait_done(n);
        check("single_latency", n, 32'd16);
        check("single_freq", {28'd0, freq}, 32'd5);
        check("single_peak", peak_mag, 32'h0001_0000);
        tick();
        check("single_done_pulse", {31'd0, done}, 32'd0);
        check("single_busy_end", {31'd0, busy}, 32'd0);
        tick();
        check("single_hold_freq", {28'd0, freq}, 32'd5);

        // Tie with sign: -1.0 in bin 3 versus j1.0 in bin 9
        clear_frame();
        fd[3] = 32'hFF00_0000;
        fd[9] = 32'h0000_0100;
        cap();
        wait_done(n);
        check("tie_freq", {28'd0, freq}, 32'd3);
        check("tie_peak", peak_mag, 32'h0001_0000);
        tick();

        // Extreme magnitudes
        clear_frame();
        fd[0]  = 32'h7FFF_7FFF;
        fd[12] = 32'h8000_8000;
        cap();
        wait_done(n);
        check("extreme_freq", {28'd0, freq}, 32'd12);
        check("extreme_peak", peak_mag, 32'h8000_0000);
        tick();

        // Back-to-back frames
        o0 = ovr_cnt;
        clear_frame();
        fd[2] = 32'h0200_0000;
        cap();
        repeat (15) tick();
        clear_frame();
        fd[14] = 32'h0000_0300;
        sb.push_back(model(fd));
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        check("b2b_first_done", {31'd0, done}, 32'd1);
        check("b2b_first_freq", {28'd0, freq}, 32'd2);
        check("b2b_busy_held", {31'd0, busy}, 32'd1);
        wait_done(n);
        check("b2b_second_latency", n, 32'd16);
        check("b2b_second_freq", {28'd0, freq}, 32'd14);
        check("b2b_no_overrun", ovr_cnt, o0);
        tick();

        // Overrun: second presentation at E5 is dropped
        clear_frame();
        fd[6] = 32'h0000_0100;
        cap();
        repeat (4) tick();
        clear_frame();
        fd[1] = 32'h4000_4000;
        fft_valid = 1'b1;
        tick();
        fft_valid = 1'b0;
        check("ovr_pulse", {31'd0, overrun}, 32'd1);
        tick();
        check("ovr_one_cycle", {31'd0, overrun}, 32'd0);
        wait_done(n);
        check("ovr_remaining", n, 32'd10);
        check("ovr_freq", {28'd0, freq}, 32'd6);
        tick();
        check("ovr_busy_end", {31'd0, busy}, 32'd0);

        // Reset mid-scan
        clear_frame();
        fd[7] = 32'h0300_0000;
        cap();
        repeat (7) tick();
        rst = 1'b1;
        tick();
        sb.delete();
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_freq", {28'd0, freq}, 32'd0);
        check("mid_rst_peak", peak_mag, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (20) tick();
        check("mid_rst_no_done", done_cnt, d0);

        // Fresh all-zero frame after reset
        clear_frame();
        cap();
        wait_done(n);
        check("zero_latency", n, 32'd16);
        check("zero_freq", {28'd0, freq}, 32'd0);
        check("zero_peak", peak_mag, 32'd0);
        tick();
        tick();
        check("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
